hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 82 ++++++++
 tb/tb_hazard_scoreboard.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: scoreboard-based stall/forward/flush controller for the ID stage
module hazard_scoreboard #(
  parameter int REG_AW      = 3,
  parameter int DEPTH       = 3,
  parameter int FWD_EN      = 1,
  parameter int LOAD_READY  = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_AW-1:0]          id_rs,
  input  logic                       id_rs_use,
  input  logic [REG_AW-1:0]          id_rt,
  input  logic                       id_rt_use,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_reg_write,
  input  logic                       id_is_load,
  input  logic                       flush,
  output logic                       stall,
  output logic                       pc_we,
  output logic                       if_id_we,
  output logic                       id_ex_bubble,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel_a,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel_b,
  output logic [CNT_W-1:0]           stall_cnt
);
  localparam int SW = $clog2(DEPTH+1);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } slot_t;
  slot_t [DEPTH-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     sel_a, sel_b;
  logic              hit_a, hit_b, lu_a, lu_b, hazard, issue;
  // youngest-match search: scan oldest to youngest so the youngest hit overwrites
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    sel_a = '0;
    sel_b = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (id_rs_use && slot_q[i].v && slot_q[i].rd == id_rs) begin
        hit_a = 1'b1;
        sel_a = SW'(i+1);
        lu_a  = slot_q[i].ld && (i < LOAD_READY);
      end
      if (id_rt_use && slot_q[i].v && slot_q[i].rd == id_rt) begin
        hit_b = 1'b1;
        sel_b = SW'(i+1);
        lu_b  = slot_q[i].ld && (i < LOAD_READY);
      end
    end
  end
  assign hazard       = (FWD_EN != 0) ? (lu_a | lu_b) : (hit_a | hit_b);
  assign stall        = id_valid & hazard & ~flush;
  assign id_ex_bubble = id_valid & (hazard | flush);
  assign pc_we        = ~stall;
  assign if_id_we     = ~stall;
  assign fwd_sel_a    = (FWD_EN != 0) ? sel_a : '0;
  assign fwd_sel_b    = (FWD_EN != 0) ? sel_b : '0;
  assign issue        = id_valid & ~stall & ~flush;
  assign stall_cnt    = cnt_q;
  // shift the scoreboard, then kill the youngest slots on a flush
  always_comb begin
    slot_d    = '0;
    slot_d[0] = (issue && id_reg_write) ? {1'b1, id_rd, id_is_load} : '0;
    for (int i = 1; i < DEPTH; i++) slot_d[i] = slot_q[i-1];
    for (int i = 0; i < FLUSH_DEPTH && i < DEPTH; i++) slot_d[i] = flush ? '0 : slot_d[i];
    cnt_d = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    slot_q <= rst ? '0 : slot_d;
    cnt_q  <= rst ? '0 : cnt_d;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of forwarding, load-use, stall-only, flush and saturation
module tb_hazard_scoreboard;
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid, id_rs_use, id_rt_use, id_reg_write, id_is_load, flush;
  logic [2:0] id_rs, id_rt, id_rd;
  logic d_stall, d_pcwe, d_ifwe, d_bub;
  logic [1:0] d_fa, d_fb;
  logic [15:0] d_cnt;
  logic s_stall, s_pcwe, s_ifwe, s_bub;
  logic [1:0] s_fa, s_fb;
  logic [15:0] s_cnt;
  logic t_stall, t_pcwe, t_ifwe, t_bub;
  logic [1:0] t_fa, t_fb;
  logic [1:0] t_cnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  hazard_scoreboard u_def (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
    .id_rt(id_rt), .id_rt_use(id_rt_use), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .flush(flush), .stall(d_stall), .pc_we(d_pcwe), .if_id_we(d_ifwe),
    .id_ex_bubble(d_bub), .fwd_sel_a(d_fa), .fwd_sel_b(d_fb), .stall_cnt(d_cnt));
  hazard_scoreboard #(.FWD_EN(0)) u_so (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
    .id_rt(id_rt), .id_rt_use(id_rt_use), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .flush(flush), .stall(s_stall), .pc_we(s_pcwe), .if_id_we(s_ifwe),
    .id_ex_bubble(s_bub), .fwd_sel_a(s_fa), .fwd_sel_b(s_fb), .stall_cnt(s_cnt));
  hazard_scoreboard #(.FWD_EN(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
    .id_rt(id_rt), .id_rt_use(id_rt_use), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .flush(flush), .stall(t_stall), .pc_we(t_pcwe), .if_id_we(t_ifwe),
    .id_ex_bubble(t_bub), .fwd_sel_a(t_fa), .fwd_sel_b(t_fb), .stall_cnt(t_cnt));
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                       input logic rtu, input logic [2:0] rd, input logic rw, input logic ld);
    id_valid = v; id_rs = rs; id_rs_use = rsu; id_rt = rt; id_rt_use = rtu;
    id_rd = rd; id_reg_write = rw; id_is_load = ld;
    #1;
  endtask
  task automatic do_reset();
    flush = 1'b0;
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    flush = 1'b0;
    rst = 1'b1;
    drive(1, 3'd1, 1, 3'd1, 1, 3'd1, 1, 1);
    cyc();
    cyc();
    rst = 1'b0;
    drive(1, 3'd1, 1, 3'd1, 1, 3'd0, 0, 0);
    total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", d_stall); end
    total++; if (d_bub !== 1'b0) begin bad++; $display("FAIL reset_bubble got=%0d exp=0", d_bub); end
    total++; if (d_pcwe !== 1'b1 || d_ifwe !== 1'b1) begin bad++; $display("FAIL reset_we got=%0d%0d exp=11", d_pcwe, d_ifwe); end
    total++; if (d_fa !== 2'd0 || d_fb !== 2'd0) begin bad++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", d_fa, d_fb); end
    total++; if (d_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", d_cnt); end
    total++; if (s_stall !== 1'b0) begin bad++; $display("FAIL reset_so_stall got=%0d exp=0", s_stall); end
  endtask
  task automatic test_ex_forward();
    do_reset();
    drive(1, 0, 0, 0, 0, 3'd1, 1, 0);
    cyc();
    drive(1, 3'd1, 1, 0, 0, 0, 0, 0);
    total++; if (d_fa !== 2'd1) begin bad++; $display("FAIL ex_fwd_a got=%0d exp=1", d_fa); end
    total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL ex_fwd_stall got=%0d exp=0", d_stall); end
    cyc();
    drive(1, 0, 0, 3'd1, 1, 0, 0, 0);
    total++; if (d_fb !== 2'd2) begin bad++; $display("FAIL mem_fwd_b got=%0d exp=2", d_fb); end
    total++; if (d_fa !== 2'd0) begin bad++; $display("FAIL mem_fwd_a_unused got=%0d exp=0", d_fa); end
    cyc();
    cyc();
    drive(1, 3'd1, 1, 3'd1, 1, 0, 0, 0);
    total++; if (d_fa !== 2'd0 || d_fb !== 2'd0) begin bad++; $display("FAIL retired_fwd got=%0d/%0d exp=0/0", d_fa, d_fb); end
    cyc();
  endtask
  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 3'd2, 1, 1);
    cyc();
    drive(0, 0, 0, 3'd2, 1, 0, 0, 0);
    total++; if (d_stall !== 1'b0 || d_bub !== 1'b0) begin bad++; $display("FAIL lu_invalid_id got=%0d%0d exp=00", d_stall, d_bub); end
    drive(1, 0, 0, 3'd2, 1, 0, 0, 0);
    total++; if (d_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0d exp=1", d_stall); end
    total++; if (d_bub !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%0d exp=1", d_bub); end
    total++; if (d_pcwe !== 1'b0 || d_ifwe !== 1'b0) begin bad++; $display("FAIL lu_we got=%0d%0d exp=00", d_pcwe, d_ifwe); end
    cyc();
    total++; if (d_stall !== 1'b0 || d_bub !== 1'b0) begin bad++; $display("FAIL lu_release got=%0d%0d exp=00", d_stall, d_bub); end
    total++; if (d_fb !== 2'd2) begin bad++; $display("FAIL lu_fwd_b got=%0d exp=2", d_fb); end
    total++; if (d_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", d_cnt); end
    cyc();
    total++; if (d_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt_hold got=%0d exp=1", d_cnt); end
  endtask
  task automatic test_priority();
    do_reset();
    drive(1, 0, 0, 0, 0, 3'd3, 1, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 3'd5, 1, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 3'd3, 1, 0);
    cyc();
    drive(1, 3'd3, 1, 3'd5, 1, 0, 0, 0);
    total++; if (d_fa !== 2'd1) begin bad++; $display("FAIL prio_a got=%0d exp=1", d_fa); end
    total++; if (d_fb !== 2'd2) begin bad++; $display("FAIL prio_b got=%0d exp=2", d_fb); end
    total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL prio_stall got=%0d exp=0", d_stall); end
    cyc();
  endtask
  task automatic test_stall_only();
    do_reset();
    drive(1, 0, 0, 0, 0, 3'd1, 1, 0);
    cyc();
    drive(1, 3'd1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      total++; if (s_stall !== 1'b1) begin bad++; $display("FAIL so_stall_%0d got=%0d exp=1", i, s_stall); end
      cyc();
    end
    total++; if (s_stall !== 1'b0) begin bad++; $display("FAIL so_release got=%0d exp=0", s_stall); end
    total++; if (s_fa !== 2'd0) begin bad++; $display("FAIL so_fwd_a got=%0d exp=0", s_fa); end
    total++; if (s_cnt !== 16'd3) begin bad++; $display("FAIL so_cnt got=%0d exp=3", s_cnt); end
    cyc();
  endtask
  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 0, 0, 3'd2, 1, 1);
    cyc();
    flush = 1'b1;
    drive(1, 0, 0, 3'd2, 1, 3'd6, 1, 0);
    total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0d exp=0", d_stall); end
    total++; if (d_bub !== 1'b1) begin bad++; $display("FAIL flush_bubble got=%0d exp=1", d_bub); end
    total++; if (d_pcwe !== 1'b1) begin bad++; $display("FAIL flush_pcwe got=%0d exp=1", d_pcwe); end
    cyc();
    flush = 1'b0;
    drive(1, 3'd6, 1, 3'd2, 1, 0, 0, 0);
    total++; if (d_cnt !== 16'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", d_cnt); end
    total++; if (d_fa !== 2'd0) begin bad++; $display("FAIL flush_slot0 got=%0d exp=0", d_fa); end
    total++; if (d_fb !== 2'd2 || d_stall !== 1'b0) begin bad++; $display("FAIL flush_shift got=%0d/%0d exp=2/0", d_fb, d_stall); end
    cyc();
  endtask
  task automatic test_saturate();
    int seen;
    seen = 0;
    do_reset();
    drive(1, 0, 0, 0, 0, 3'd1, 1, 0);
    cyc();
    drive(1, 3'd1, 1, 0, 0, 3'd1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (t_stall === 1'b1) seen++;
      cyc();
    end
    total++; if (seen != 6) begin bad++; $display("FAIL sat_stall_cycles got=%0d exp=6", seen); end
    total++; if (t_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", t_cnt); end
    total++; if (s_cnt !== 16'd6) begin bad++; $display("FAIL wide_cnt got=%0d exp=6", s_cnt); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    total++; if (t_cnt !== 2'd0 || s_cnt !== 16'd0) begin bad++; $display("FAIL midrst_cnt got=%0d/%0d exp=0/0", t_cnt, s_cnt); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
  initial begin
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_ex_forward();
    test_load_use();
    test_priority();
    test_stall_only();
    test_flush();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
